// File: rtl/project_sched_pkg.sv
// Shared types and register map for the project switch sequencer.
package project_sched_pkg;

    // Handover states; encoding is visible in STATUS[1:0].
    typedef enum logic [1:0] {
        ST_ISOLATE = 2'd0,
        ST_RESET   = 2'd1,
        ST_ACTIVE  = 2'd2
    } state_e;

    // Register offsets inside the 16-byte window.
    localparam logic [3:0] OFF_SELECT = 4'h0;
    localparam logic [3:0] OFF_CTRL   = 4'h4;
    localparam logic [3:0] OFF_PERIOD = 4'h8;
    localparam logic [3:0] OFF_STATUS = 4'hC;

    // STATUS field positions.
    localparam int STATUS_STATE_LSB  = 0;
    localparam int STATUS_ERR_BIT    = 8;
    localparam int STATUS_TARGET_LSB = 16;

    // Next project for auto-rotate, wrapping modulo the project count
    // rather than relying on 8-bit overflow.
    function automatic logic [7:0] next_project(input logic [7:0] cur, input logic [7:0] count);
        logic [8:0] inc;
        inc = {1'b0, cur} + 9'd1;
        return (inc >= {1'b0, count}) ? 8'd0 : inc[7:0];
    endfunction

endpackage

// File: rtl/project_switch_sequencer_if.sv
// Wishbone slave bus bundle for the project switch sequencer.
interface project_switch_sequencer_if;
    logic        wbs_stb_i;
    logic        wbs_cyc_i;
    logic        wbs_we_i;
    logic [3:0]  wbs_sel_i;
    logic [31:0] wbs_adr_i;
    logic [31:0] wbs_dat_i;
    logic        wbs_ack_o;
    logic [31:0] wbs_dat_o;

    modport master (
        output wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
        input  wbs_ack_o, wbs_dat_o
    );

    modport slave (
        input  wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
        output wbs_ack_o, wbs_dat_o
    );
endinterface

// File: rtl/sched_rotate_timer.sv
// 32-bit auto-rotate period counter: counts 0..period-1 and pulses expire
// on the last count.
module sched_rotate_timer (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic        clear,
    input  logic [31:0] period,
    output logic        expire
);

    logic [31:0] count_q;
    logic        at_end;

    assign at_end = (count_q == period - 32'd1);
    assign expire = enable && !clear && (period != 32'd0) && at_end;

    // Period counter; clear has priority over counting.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else if (clear) begin
            count_q <= '0;
        end else if (enable) begin
            count_q <= at_end ? 32'd0 : count_q + 32'd1;
        end
    end

endmodule

// File: rtl/project_switch_sequencer.sv
// Owns project selection: Wishbone register file, glitch-free handover FSM
// (isolate pads, hold reset, release) and the auto-rotate hookup.
module project_switch_sequencer
    import project_sched_pkg::*;
#(
    parameter logic [31:0] address_base = 32'h3000_0500,
    parameter int          num_projects = 5,
    parameter int          guard_cycles = 4,
    parameter int          reset_cycles = 8
) (
    input  logic                    wb_clk_i,
    input  logic                    wb_rst_i,
    project_switch_sequencer_if.slave wbs,
    output logic [7:0]              active_project,
    output logic [num_projects-1:0] proj_reset,
    output logic                    io_isolate,
    output logic                    busy
);

    localparam int CNT_MAX = (guard_cycles > reset_cycles) ? guard_cycles : reset_cycles;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] GUARD_LOAD = CNT_W'(guard_cycles);
    localparam logic [CNT_W-1:0] RESET_LOAD = CNT_W'(reset_cycles);
    localparam logic [7:0]       NUM_P8     = 8'(num_projects);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]       target_q, target_d;
    logic [7:0]       active_d;

    logic        err_q, auto_rotate_q, acked_q, ack_q;
    logic [31:0] period_q, dat_q, rd_data;

    logic       hit, stb_act, new_req, wr;
    logic [3:0] off;
    logic [7:0] sel_val;
    logic       sel_wr, ctrl_wr, period_wr, status_wr;
    logic       in_active, sel_ok, start_manual, sel_err;
    logic       rot_enable, rot_clear, rot_expire;

    // Bus decode; a request is taken once per strobe.
    assign hit       = (wbs.wbs_adr_i[31:4] == address_base[31:4]);
    assign stb_act   = wbs.wbs_cyc_i && wbs.wbs_stb_i;
    assign new_req   = stb_act && hit && !acked_q;
    assign wr        = new_req && wbs.wbs_we_i;
    assign off       = wbs.wbs_adr_i[3:0];
    assign sel_val   = wbs.wbs_dat_i[7:0];
    assign sel_wr    = wr && (off == OFF_SELECT) && wbs.wbs_sel_i[0];
    assign ctrl_wr   = wr && (off == OFF_CTRL)   && wbs.wbs_sel_i[0];
    assign period_wr = wr && (off == OFF_PERIOD) && (wbs.wbs_sel_i == 4'hF);
    assign status_wr = wr && (off == OFF_STATUS) && wbs.wbs_sel_i[1]
                       && wbs.wbs_dat_i[STATUS_ERR_BIT];

    assign in_active    = (state_q == ST_ACTIVE);
    assign sel_ok       = (sel_val < NUM_P8);
    assign start_manual = sel_wr && sel_ok && in_active;
    assign sel_err      = sel_wr && (!sel_ok || !in_active);

    assign rot_enable = in_active && auto_rotate_q && (period_q != 32'd0);
    assign rot_clear  = period_wr || !auto_rotate_q || !in_active;

    sched_rotate_timer u_rotate (
        .clk    (wb_clk_i),
        .reset  (wb_rst_i),
        .enable (rot_enable),
        .clear  (rot_clear),
        .period (period_q),
        .expire (rot_expire)
    );

    // FSM state register and handover bookkeeping.
    always_ff @(posedge wb_clk_i) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values regardless of statement order.
        if (wb_rst_i) begin
            state_q        <= ST_RESET;
            cnt_q          <= RESET_LOAD;
            target_q       <= 8'd0;
            active_project <= 8'd0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            target_q       <= target_d;
            active_project <= active_d;
        end
    end

    // FSM next state: the counter holds remaining cycles in the current state.
    always_comb begin
        // NOTE: every output gets a default first so no path infers a latch.
        state_d  = state_q;
        cnt_d    = cnt_q;
        target_d = target_q;
        active_d = active_project;
        case (state_q)
            ST_ISOLATE: begin
                if (cnt_q <= CNT_W'(1)) begin
                    state_d  = ST_RESET;
                    cnt_d    = RESET_LOAD;
                    active_d = target_q;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_RESET: begin
                if (cnt_q <= CNT_W'(1)) begin
                    state_d = ST_ACTIVE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_ACTIVE: begin
                // A manual select beats a simultaneous rotate expiry.
                if (start_manual) begin
                    state_d  = ST_ISOLATE;
                    cnt_d    = GUARD_LOAD;
                    target_d = sel_val;
                end else if (rot_expire) begin
                    state_d  = ST_ISOLATE;
                    cnt_d    = GUARD_LOAD;
                    target_d = next_project(active_project, NUM_P8);
                end
            end
            default: begin
                state_d  = ST_RESET;
                cnt_d    = RESET_LOAD;
                target_d = 8'd0;
            end
        endcase
    end

    // Register read mux.
    always_comb begin
        rd_data = '0;
        case (off)
            OFF_SELECT: rd_data[7:0] = active_project;
            OFF_CTRL:   rd_data[0]   = auto_rotate_q;
            OFF_PERIOD: rd_data      = period_q;
            OFF_STATUS: begin
                rd_data[STATUS_STATE_LSB +: 2]  = state_q;
                rd_data[STATUS_ERR_BIT]         = err_q;
                rd_data[STATUS_TARGET_LSB +: 8] = target_q;
            end
            default: rd_data = '0;
        endcase
    end

    // Register file and single-pulse Wishbone ack.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            err_q         <= 1'b0;
            auto_rotate_q <= 1'b0;
            period_q      <= '0;
            acked_q       <= 1'b0;
            ack_q         <= 1'b0;
            dat_q         <= '0;
        end else begin
            if (!stb_act) begin
                acked_q <= 1'b0;
            end else if (new_req) begin
                acked_q <= 1'b1;
            end
            ack_q <= new_req;
            dat_q <= (new_req && !wbs.wbs_we_i) ? rd_data : 32'd0;
            if (sel_err) begin
                err_q <= 1'b1;
            end else if (status_wr) begin
                err_q <= 1'b0;
            end
            if (ctrl_wr) begin
                auto_rotate_q <= wbs.wbs_dat_i[0];
            end
            if (period_wr) begin
                period_q <= wbs.wbs_dat_i;
            end
        end
    end

    assign wbs.wbs_ack_o = ack_q;
    assign wbs.wbs_dat_o = dat_q;

    assign io_isolate = (state_q != ST_ACTIVE);
    assign busy       = (state_q != ST_ACTIVE);

    // Only the active project may run, and not while it is being reset.
    always_comb begin
        proj_reset = '1;
        for (int i = 0; i < num_projects; i++) begin
            proj_reset[i] = !((active_project == 8'(i)) && (state_q != ST_RESET));
        end
    end

endmodule

// File: tb/tb_project_switch_sequencer.sv
// Directed self-checking bench for project_switch_sequencer (default parameters).
module tb_project_switch_sequencer;

    localparam logic [31:0] BASE = 32'h3000_0500;

    logic       clk;
    logic       rst;
    logic [7:0] active_project;
    logic [4:0] proj_reset;
    logic       io_isolate;
    logic       busy;

    int checks;
    int failures;
    int n;

    project_switch_sequencer_if bus ();

    project_switch_sequencer dut (
        .wb_clk_i       (clk),
        .wb_rst_i       (rst),
        .wbs            (bus.slave),
        .active_project (active_project),
        .proj_reset     (proj_reset),
        .io_isolate     (io_isolate),
        .busy           (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int count);
        for (int i = 0; i < count; i++) tick();
    endtask

    task automatic bus_start(input logic we, input logic [3:0] off, input logic [31:0] dat,
                             input logic [3:0] sel);
        bus.wbs_cyc_i = 1'b1;
        bus.wbs_stb_i = 1'b1;
        bus.wbs_we_i  = we;
        bus.wbs_adr_i = BASE | {28'd0, off};
        bus.wbs_dat_i = dat;
        bus.wbs_sel_i = sel;
    endtask

    task automatic bus_idle();
        bus.wbs_cyc_i = 1'b0;
        bus.wbs_stb_i = 1'b0;
        bus.wbs_we_i  = 1'b0;
    endtask

    // Write: returns right after the ack cycle (T+1), bus idle.
    task automatic wb_write(input string tag, input logic [3:0] off, input logic [31:0] dat,
                            input logic [3:0] sel);
        bus_start(1'b1, off, dat, sel);
        tick();
        check({tag, "_ack"}, 32'(bus.wbs_ack_o), 32'd1);
        bus_idle();
    endtask

    task automatic wb_read(input string tag, input logic [3:0] off, input logic [31:0] exp);
        bus_start(1'b0, off, 32'd0, 4'hF);
        tick();
        check({tag, "_ack"}, 32'(bus.wbs_ack_o), 32'd1);
        check({tag, "_dat"}, bus.wbs_dat_o, exp);
        bus_idle();
        tick();
    endtask

    // Bounded wait for busy to reach a level; n returns the ticks taken.
    task automatic wait_busy(input string tag, input logic level, input int limit, output int cnt);
        cnt = 0;
        while (busy !== level && cnt < limit) begin
            tick();
            cnt++;
        end
        check(tag, 32'(busy), 32'(level));
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        bus.wbs_cyc_i = 1'b0;
        bus.wbs_stb_i = 1'b0;
        bus.wbs_we_i  = 1'b0;
        bus.wbs_sel_i = 4'h0;
        bus.wbs_adr_i = 32'd0;
        bus.wbs_dat_i = 32'd0;
        ticks(2);

        // Reset values
        check("rst_active", 32'(active_project), 32'd0);
        check("rst_preset", 32'(proj_reset), 32'h1F);
        check("rst_iso", 32'(io_isolate), 32'd1);
        check("rst_busy", 32'(busy), 32'd1);
        check("rst_ack", 32'(bus.wbs_ack_o), 32'd0);
        check("rst_dat", bus.wbs_dat_o, 32'd0);

        // Release: ACTIVE on project 0 eight clocks later
        rst = 1'b0;
        ticks(7);
        check("boot_busy7", 32'(busy), 32'd1);
        tick();
        check("boot_busy8", 32'(busy), 32'd0);
        check("boot_iso8", 32'(io_isolate), 32'd0);
        check("boot_preset", 32'(proj_reset), 32'h1E);
        check("boot_active", 32'(active_project), 32'd0);

        // Switch to 3 (T+1 right after wb_write)
        wb_write("sel3", 4'h0, 32'd3, 4'h1);
        check("sel3_iso_t1", 32'(io_isolate), 32'd1);
        tick();
        check("sel3_ack_pulse", 32'(bus.wbs_ack_o), 32'd0);
        ticks(2);
        check("sel3_old_t4", 32'(active_project), 32'd0);
        check("sel3_old_runs", 32'(proj_reset), 32'h1E);
        tick();
        check("sel3_new_t5", 32'(active_project), 32'd3);
        check("sel3_allrst_t5", 32'(proj_reset), 32'h1F);
        ticks(7);
        check("sel3_busy_t12", 32'(busy), 32'd1);
        tick();
        check("sel3_busy_t13", 32'(busy), 32'd0);
        check("sel3_iso_t13", 32'(io_isolate), 32'd0);
        check("sel3_preset", 32'(proj_reset), 32'h17);
        wb_read("rd_sel", 4'h0, 32'd3);
        wb_read("rd_stat3", 4'hC, 32'h0003_0002);

        // Ack is one pulse even with strobe held
        bus_start(1'b0, 4'h0, 32'd0, 4'hF);
        tick();
        check("hold_ack1", 32'(bus.wbs_ack_o), 32'd1);
        tick();
        check("hold_ack2", 32'(bus.wbs_ack_o), 32'd0);
        check("hold_dat2", bus.wbs_dat_o, 32'd0);
        bus_idle();
        tick();

        // Out-of-range select: acked, ignored, sets err
        wb_write("sel7", 4'h0, 32'd7, 4'h1);
        check("sel7_iso", 32'(io_isolate), 32'd0);
        tick();
        wb_read("rd_err1", 4'hC, 32'h0003_0102);
        wb_write("clr_err", 4'hC, 32'h0000_0100, 4'hF);
        tick();
        wb_read("rd_err0", 4'hC, 32'h0003_0002);

        // Select while busy: ignored, err set, original switch completes
        wb_write("sel1", 4'h0, 32'd1, 4'h1);
        tick();
        wb_write("sel2_busy", 4'h0, 32'd2, 4'h1);
        tick();
        tick();
        check("busy_sw_t5", 32'(active_project), 32'd1);
        ticks(8);
        check("busy_sw_t13", 32'(busy), 32'd0);
        check("busy_sw_active", 32'(active_project), 32'd1);
        check("busy_sw_preset", 32'(proj_reset), 32'h1D);
        wb_read("rd_busy_err", 4'hC, 32'h0001_0102);
        wb_write("clr_err2", 4'hC, 32'h0000_0100, 4'h2);
        tick();

        // Back to 0, then auto-rotate with PERIOD=20
        wb_write("sel0", 4'h0, 32'd0, 4'h1);
        ticks(12);
        check("sel0_active", 32'(active_project), 32'd0);
        check("sel0_busy", 32'(busy), 32'd0);
        wb_write("period", 4'h8, 32'd20, 4'hF);
        tick();
        wb_write("ctrl_on", 4'h4, 32'd1, 4'h1);
        tick();
        wait_busy("rot1_start", 1'b1, 40, n);
        wait_busy("rot1_done", 1'b0, 20, n);
        check("rot1_len", 32'(n), 32'd12);
        check("rot1_proj", 32'(active_project), 32'd1);
        for (int p = 2; p <= 5; p++) begin
            wait_busy("rot_start", 1'b1, 40, n);
            check("rot_period", 32'(n), 32'd20);
            wait_busy("rot_done", 1'b0, 20, n);
            check("rot_len", 32'(n), 32'd12);
            check("rot_proj", 32'(active_project), 32'(p % 5));
        end
        wb_write("ctrl_off", 4'h4, 32'd0, 4'h1);
        ticks(30);
        check("rot_off_busy", 32'(busy), 32'd0);
        check("rot_off_proj", 32'(active_project), 32'd0);
        wb_read("rd_period", 4'h8, 32'd20);
        wb_read("rd_ctrl", 4'h4, 32'd0);

        // Select with the wrong byte mask: acked, no effect
        wb_write("sel_mask", 4'h0, 32'd2, 4'h2);
        check("sel_mask_iso", 32'(io_isolate), 32'd0);
        tick();
        check("sel_mask_proj", 32'(active_project), 32'd0);

        // Reset in the middle of a switch to 4
        wb_write("sel4", 4'h0, 32'd4, 4'h1);
        ticks(5);
        check("sel4_mid_proj", 32'(active_project), 32'd4);
        check("sel4_mid_preset", 32'(proj_reset), 32'h1F);
        rst = 1'b1;
        tick();
        check("mid_rst_proj", 32'(active_project), 32'd0);
        check("mid_rst_preset", 32'(proj_reset), 32'h1F);
        check("mid_rst_iso", 32'(io_isolate), 32'd1);
        rst = 1'b0;
        ticks(7);
        check("mid_rst_busy7", 32'(busy), 32'd1);
        tick();
        check("mid_rst_busy8", 32'(busy), 32'd0);
        check("mid_rst_active", 32'(active_project), 32'd0);
        check("mid_rst_final", 32'(proj_reset), 32'h1E);
        wb_read("rd_stat_rst", 4'hC, 32'h0000_0002);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/project_switch_sequencer.md
# project_switch_sequencer

Sequencer that owns project selection for the multi-project harness. It takes Wishbone writes to a select register and runs a glitch-free handover: pads isolated, old and new projects held in reset, then the new project released. An optional auto-rotate timer steps through projects periodically. Its outputs drive the harness pad muxes and the per-project reset inputs.

## Interface
- `address_base`, default 32'h30000500: base of a 16-byte register window.
- `num_projects`, default 5: number of selectable projects, range 1..255.
- `guard_cycles`, default 4: cycles of pad isolation before any reset asserts, range ≥1.
- `reset_cycles`, default 8: cycles the incoming project is held in reset, range ≥1.
- `wb_clk_i` in 1: clock.
- `wb_rst_i` in 1: synchronous, active-high reset.
- `wbs_stb_i`, `wbs_cyc_i`, `wbs_we_i` in 1: Wishbone strobe, cycle, write enable.
- `wbs_sel_i` in 4: byte selects.
- `wbs_adr_i`, `wbs_dat_i` in 32: address and write data.
- `wbs_ack_o` out 1: ack, asserted only for addresses in this block's window.
- `wbs_dat_o` out 32: read data; 0 whenever ack is low.
- `active_project` out 8: project whose pads are muxed in.
- `proj_reset` out `num_projects`: per-project reset, active-high.
- `io_isolate` out 1: high forces the harness to drive `io_out`=0 and `io_oeb`=all 1.
- `busy` out 1: high in any state other than ACTIVE.

## Operation
- Registers at `address_base` +:
  - +0x0 SELECT: write [7:0] = target project, needs `sel[0]`. Read returns `active_project`.
  - +0x4 CTRL: bit0 `auto_rotate`. Reset value 0.
  - +0x8 PERIOD: 32-bit rotate period in clocks. Written only when `sel`=4'hF. Reset value 0, and 0 disables rotation.
  - +0xC STATUS, read-only:
    - [1:0] state
    - [8] `err`, sticky, cleared by writing STATUS with `dat[8]`=1
    - [23:16] target
- States:
  - ISOLATE: `io_isolate`=1. The old project keeps running. Lasts `guard_cycles`.
  - RESET: on entry, `active_project` ← target. `io_isolate`=1, and the target's `proj_reset` bit is 1. Lasts `reset_cycles`.
  - ACTIVE: `io_isolate`=0 and the target's reset bit is 0.
- `proj_reset` bits of every non-active project are always 1.
- Switch request:
  - A SELECT write in ACTIVE with value < `num_projects` starts ISOLATE. This applies even when the value equals the current project, so a same-project write acts as a soft reset.
  - A SELECT write with value ≥ `num_projects` is ignored and sets `err`.
  - A SELECT write while `busy` is ignored and sets `err`.
  - All three cases are acked.
- Auto-rotate:
  - Applies in ACTIVE with `auto_rotate`=1 and PERIOD≠0.
  - The counter runs 0..PERIOD-1. At PERIOD-1 a switch to (`active_project`+1) mod `num_projects` starts.
  - The counter clears on entering ACTIVE, on any PERIOD write, and when `auto_rotate` is 0.
- A manual SELECT write in the same cycle as rotate expiry wins; the rotate expiry is dropped.
- Writes to the window with an unused byte mask are acked with no effect.

## Timing
- Reset values:
  - `active_project`=0, `proj_reset`=all 1, `io_isolate`=1, `busy`=1.
  - `wbs_ack_o`=0, `wbs_dat_o`=0, `err`=0.
  - State = RESET with target 0 and the counter loaded with `reset_cycles`.
- Out of reset: ACTIVE on project 0 after `reset_cycles` clocks.
- Wishbone:
  - `wbs_ack_o` is registered and asserts 1 cycle after `cyc&stb` with an in-window address.
  - Ack is a single-cycle pulse. It deasserts even if `stb` is held, and no re-ack is issued until `stb` drops.
  - Read data is valid in the ack cycle.
- Switch latency, from the SELECT write cycle T:
  - `io_isolate` rises at T+1.
  - `active_project` changes at T+1+`guard_cycles`.
  - `io_isolate` and `busy` fall at T+1+`guard_cycles`+`reset_cycles`.
- `wb_rst_i` mid-sequence returns to the reset values in the next cycle; any in-flight target is discarded.
- Widths: the rotate counter is 32-bit and the guard/reset counter is ≥$clog2(max(guard,reset)+1). Increment of `active_project` wraps modulo `num_projects`, never 8-bit overflow.

## Structure
- Package `project_sched_pkg` holds:
  - the state enum (ISOLATE=0, RESET=1, ACTIVE=2)
  - register offsets 0x0/0x4/0x8/0xC
  - STATUS field positions
- Sub-module `sched_rotate_timer` contains the 32-bit period counter with `enable`, `clear` and `period` inputs and an `expire` pulse output.
- Everything else (FSM, register file, Wishbone ack) lives in the top module.

## Test plan
- Reset release, defaults → project 0 ACTIVE at cycle 8; `proj_reset`=5'b11110 and `io_isolate`=0.
- Write SELECT=3 at cycle T → ack at T+1, `io_isolate`=1 at T+1, `active_project`=3 at T+5, `proj_reset`=5'b10111 and `io_isolate`=0 at T+13.
- Write SELECT=7 → ack, no state change, STATUS[8]=1. Then write STATUS with bit 8 set → `err` reads 0.
- SELECT=2 issued while `busy` → ignored and `err`=1; the original switch completes unchanged.
- CTRL=1, PERIOD=20 → projects rotate 0→1→2→3→4→0. Each rotation starts 20 cycles after ACTIVE entry; the wrap from 4 to 0 is checked.
- Assert `wb_rst_i` during the RESET state of a switch to 4 → next cycle `active_project`=0 and `proj_reset`=all 1; project 0 is ACTIVE 8 cycles after release.
